// File: rtl/rf_pkg.sv
// Shared sizing constants for the 8-entry register file and its write-select encoder.
package rf_pkg;
  localparam int          RF_NUM_REGS = 8;
  localparam int          RF_ADDR_W   = 3;
  localparam int          RF_DATA_W   = 16;
  localparam logic [7:0]  RF_WE_NONE  = 8'h00;
endpackage

// File: rtl/rf_onehot_encode.sv
// Classifies the decoder's write select as none / legal one-hot / multi-hot and encodes its index.
module rf_onehot_encode
  import rf_pkg::*;
(
  input  logic [RF_NUM_REGS-1:0] we_onehot,
  output logic                   valid,
  output logic                   multi,
  output logic [RF_ADDR_W-1:0]   idx
);

  logic any_set;
  logic single;

  // x & (x-1) clears the lowest set bit; zero afterwards means at most one bit was set.
  assign any_set = (we_onehot != RF_WE_NONE);
  assign single  = ((we_onehot & (we_onehot - 8'd1)) == RF_WE_NONE);
  assign valid   = any_set && single;
  assign multi   = any_set && !single;

  always_comb begin
    idx = '0;
    for (int i = 0; i < RF_NUM_REGS; i++) begin
      if (we_onehot[i]) idx = RF_ADDR_W'(i);
    end
  end

endmodule

// File: rtl/regfile8_onehot.sv
// 8 x DATA_W register file with one-hot write port, two registered read ports and a sticky
// multi-hot error flag. Define REGFILE_BYPASS_EN for write-through forwarding on same-edge collisions.
module regfile8_onehot
  import rf_pkg::*;
#(
  parameter int DATA_W  = RF_DATA_W,
  parameter int R0_ZERO = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [RF_NUM_REGS-1:0] we_onehot,
  input  logic [DATA_W-1:0]      wdata,
  input  logic                   ra_en,
  input  logic [RF_ADDR_W-1:0]   ra_addr,
  output logic [DATA_W-1:0]      ra_data,
  input  logic                   rb_en,
  input  logic [RF_ADDR_W-1:0]   rb_addr,
  output logic [DATA_W-1:0]      rb_data,
  input  logic                   clr_err,
  output logic                   wsel_err
);

  logic [DATA_W-1:0]    regs [RF_NUM_REGS];
  logic                 wr_valid;
  logic                 wr_multi;
  logic [RF_ADDR_W-1:0] wr_idx;
  logic                 wr_en;
  logic [DATA_W-1:0]    ra_next;
  logic [DATA_W-1:0]    rb_next;

  rf_onehot_encode u_enc (
    .we_onehot (we_onehot),
    .valid     (wr_valid),
    .multi     (wr_multi),
    .idx       (wr_idx)
  );

  // Writes to a hardwired-zero r0 are dropped without flagging an error.
  assign wr_en = wr_valid && !((R0_ZERO != 0) && (wr_idx == '0));

  function automatic logic [DATA_W-1:0] read_val(input logic [RF_ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    if ((R0_ZERO != 0) && (addr == '0))
      val = '0;
`ifdef REGFILE_BYPASS_EN
    else if (wr_valid && (wr_idx == addr))
      val = wdata;
`endif
    else
      val = regs[addr];
    return val;
  endfunction

  always_comb begin
    ra_next = read_val(ra_addr);
    rb_next = read_val(rb_addr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < RF_NUM_REGS; i++) regs[i] <= '0;
      ra_data  <= '0;
      rb_data  <= '0;
      wsel_err <= 1'b0;
    end else begin
      if (wr_en) regs[wr_idx] <= wdata;
      if (ra_en) ra_data <= ra_next;
      if (rb_en) rb_data <= rb_next;
      // A multi-hot select on the same edge as clr_err keeps the flag set.
      if (wr_multi)     wsel_err <= 1'b1;
      else if (clr_err) wsel_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile8_onehot.sv
// Scoreboard bench for regfile8_onehot: directed plan followed by random traffic against an array model.
module tb_regfile8_onehot;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  we_onehot;
  logic [15:0] wdata;
  logic        ra_en, rb_en, clr_err;
  logic [2:0]  ra_addr, rb_addr;
  logic [15:0] ra_data, rb_data;
  logic        wsel_err;

  regfile8_onehot dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_onehot (we_onehot),
    .wdata     (wdata),
    .ra_en     (ra_en),
    .ra_addr   (ra_addr),
    .ra_data   (ra_data),
    .rb_en     (rb_en),
    .rb_addr   (rb_addr),
    .rb_data   (rb_data),
    .clr_err   (clr_err),
    .wsel_err  (wsel_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        err;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          done     = 1'b0;

  // Reference model state: register contents and the expected output registers.
  logic [15:0] mreg [8];
  logic [15:0] m_a, m_b;
  logic        m_err;

  function automatic int find_bit(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [15:0] model_read(input logic [2:0] addr, input logic [7:0] we,
                                             input logic [15:0] wd);
    if (addr == 3'd0) return 16'h0000;
`ifdef REGFILE_BYPASS_EN
    if ($countones(we) == 1 && find_bit(we) == int'(addr)) return wd;
`else
    if (we == 8'hFF && wd == 16'h0 && 1'b0) return wd;
`endif
    return mreg[addr];
  endfunction

  task automatic cycle(input logic rstn, input logic [7:0] we, input logic [15:0] wd,
                       input logic rae, input logic [2:0] raa, input logic rbe,
                       input logic [2:0] rba, input logic clr, input string tag);
    exp_t e;
    int   ones;
    rst_n = rstn; we_onehot = we; wdata = wd;
    ra_en = rae; ra_addr = raa; rb_en = rbe; rb_addr = rba; clr_err = clr;
    ones = $countones(we);
    if (!rstn) begin
      for (int i = 0; i < 8; i++) mreg[i] = 16'h0000;
      m_a = 16'h0000; m_b = 16'h0000; m_err = 1'b0;
    end else begin
      if (rae) m_a = model_read(raa, we, wd);
      if (rbe) m_b = model_read(rba, we, wd);
      if (ones == 1 && find_bit(we) != 0) mreg[find_bit(we)] = wd;
      if (ones >= 2) m_err = 1'b1;
      else if (clr) m_err = 1'b0;
    end
    e.a = m_a; e.b = m_b; e.err = m_err; e.tag = tag;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    cycle(1'b1, 8'h00, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, tag);
  endtask

  // Monitor: every edge's registered outputs are visible by the following falling edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        n_checks += 3;
        if (ra_data !== e.a) begin
          n_fail++;
          $display("FAIL %s ra_data: got %h expected %h", e.tag, ra_data, e.a);
        end
        if (rb_data !== e.b) begin
          n_fail++;
          $display("FAIL %s rb_data: got %h expected %h", e.tag, rb_data, e.b);
        end
        if (wsel_err !== e.err) begin
          n_fail++;
          $display("FAIL %s wsel_err: got %b expected %b", e.tag, wsel_err, e.err);
        end
      end
    end
  end

  initial begin : stimulus
    logic [7:0]  we;
    logic [15:0] wd;
    int          wait_cnt;
    for (int i = 0; i < 8; i++) mreg[i] = 16'h0000;
    m_a = 16'h0000; m_b = 16'h0000; m_err = 1'b0;

    // Reset for two edges with a write presented; the write must be ignored.
    cycle(1'b0, 8'h08, 16'hFFFF, 1'b1, 3'd3, 1'b1, 3'd3, 1'b0, "reset0");
    cycle(1'b0, 8'h08, 16'hFFFF, 1'b1, 3'd3, 1'b1, 3'd3, 1'b0, "reset1");
    cycle(1'b1, 8'h00, 16'h0000, 1'b1, 3'd3, 1'b1, 3'd3, 1'b0, "post_reset_rd");

    for (int i = 1; i < 8; i++)
      cycle(1'b1, 8'(1 << i), 16'h1110 + 16'(i), 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, "wr_all");
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 8'h00, 16'h0000, 1'b1, 3'(i), 1'b1, 3'(7 - i), 1'b0, "rd_all");

    cycle(1'b1, 8'h01, 16'hBEEF, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, "wr_r0");
    cycle(1'b1, 8'h00, 16'h0000, 1'b1, 3'd0, 1'b1, 3'd0, 1'b0, "rd_r0");

    cycle(1'b1, 8'h0C, 16'hDEAD, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, "multi_wr");
    cycle(1'b1, 8'h00, 16'h0000, 1'b1, 3'd2, 1'b1, 3'd3, 1'b0, "multi_rd");
    for (int i = 0; i < 5; i++) idle("err_sticky");
    cycle(1'b1, 8'h00, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, "err_clr");
    cycle(1'b1, 8'h0C, 16'hDEAD, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, "err_reset");
    cycle(1'b1, 8'h81, 16'h5555, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, "err_set_wins");
    cycle(1'b1, 8'h00, 16'h0000, 1'b1, 3'd7, 1'b0, 3'd0, 1'b1, "err_clr2");

    cycle(1'b1, 8'h20, 16'hA5A5, 1'b1, 3'd5, 1'b1, 3'd5, 1'b0, "collision");
    cycle(1'b1, 8'h00, 16'h0000, 1'b1, 3'd5, 1'b1, 3'd5, 1'b0, "collision_next");

    cycle(1'b1, 8'h00, 16'h0000, 1'b1, 3'd3, 1'b0, 3'd0, 1'b0, "hold_setup");
    cycle(1'b1, 8'h08, 16'h0000, 1'b0, 3'd6, 1'b0, 3'd0, 1'b0, "hold");
    idle("hold_idle");

    cycle(1'b1, 8'h00, 16'h0000, 1'b0, 3'd0, 1'b1, 3'd6, 1'b0, "pre_reset_rd");
    cycle(1'b1, 8'h03, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, "pre_reset_err");
    cycle(1'b0, 8'h40, 16'h7777, 1'b0, 3'd0, 1'b1, 3'd6, 1'b0, "mid_reset");
    cycle(1'b1, 8'h00, 16'h0000, 1'b1, 3'd6, 1'b1, 3'd6, 1'b0, "after_reset_rd");

    // Random traffic: mostly legal one-hot writes, some idle, some multi-hot, rare resets.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(9))
        0, 1:    we = 8'h00;
        2:       begin
                   we = 8'($urandom);
                   if ($countones(we) < 2) we = we | 8'h81;
                 end
        default: we = 8'(1 << $urandom_range(7));
      endcase
      wd = 16'($urandom);
      cycle(($urandom_range(49) != 0), we, wd, 1'($urandom), 3'($urandom_range(7)),
            1'($urandom), 3'($urandom_range(7)), ($urandom_range(5) == 0), "random");
    end
    idle("drain");

    wait_cnt = 0;
    while (sb_q.size() != 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    done = 1'b1;
  end

  initial begin : finisher
    wait (done);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

endmodule

// File: doc/regfile8_onehot.md
Name: regfile8_onehot

Overview:
- 8-entry x 16-bit register file for the RISC16 datapath.
- Sits directly downstream of the 3-to-8 write-address decoder. Its write port takes the decoder's one-hot outputs y7..y0, packed as we_onehot[7:0] with y0 on bit 0.
- Has two synchronous read ports for operands A and B, and flags illegal (multi-hot) write selects.

Parameters:
- DATA_W, 16, register width in bits.
- R0_ZERO, 1, when 1 register 0 is hardwired to zero and writes to it are discarded.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- we_onehot  input  8  one-hot write select from the decoder; 8'h00 = no write.
- wdata  input  DATA_W  write data.
- ra_en  input  1  read port A enable.
- ra_addr  input  3  read port A address.
- ra_data  output  DATA_W  registered read data, port A.
- rb_en  input  1  read port B enable.
- rb_addr  input  3  read port B address.
- rb_data  output  DATA_W  registered read data, port B.
- clr_err  input  1  clears wsel_err.
- wsel_err  output  1  sticky flag: a multi-hot write select was seen.

Behaviour:
- Reset (rst_n==0 at edge):
  - all 8 registers, ra_data, rb_data and wsel_err become 0.
  - Any write or read presented in that cycle is discarded; reset overrides all other inputs.
- Write classification each edge (rst_n==1):
  - we_onehot==0: no write.
  - Exactly one bit i set: reg[i] <= wdata. When R0_ZERO==1 and i==0, the write is dropped silently; this is not an error.
  - Two or more bits set: no register changes and wsel_err <= 1.
- Error flag:
  - wsel_err is sticky; clr_err==1 clears it to 0.
  - If clr_err==1 and a multi-hot select arrive on the same edge, set wins and wsel_err stays 1.
- Read ports, 1-cycle latency:
  - If ra_en==1, ra_data <= reg[ra_addr] at the edge; if ra_en==0, ra_data holds its value.
  - rb_data behaves identically with rb_en and rb_addr.
  - Both ports may read the same address in the same cycle.
- Read of register 0 returns 0 when R0_ZERO==1.
- Read/write collision on the same edge to the same address (macro absent): the read returns the pre-write (old) value.
- The register write and the read register update on the same edge; there is no combinational path from inputs to outputs.
- The one-hot decode is purely combinational in front of the write port. No state machine; state consists of the register array, the two output registers and the error flag.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: on a same-edge collision where port X is enabled, a legal one-hot write targets address k, and X_addr==k, X_data <= wdata, i.e. write-through forwarding.
  - If k==0 and R0_ZERO==1, the port returns 0.
  - Multi-hot writes never forward; the port returns the stored value.
- Undefined: no forwarding; old value is returned as above.

Decomposition:
- Package rf_pkg holds:
  - RF_NUM_REGS = 8 and RF_ADDR_W = 3.
  - RF_DATA_W = 16, the default for DATA_W.
  - Localparam RF_WE_NONE = 8'h00.
- Sub-module rf_onehot_encode:
  - input we_onehot[7:0].
  - outputs valid (exactly one bit set), multi (two or more bits set), idx[2:0] (encoded index).
  - Instantiated once on the write path and reused by the bypass compare.

Test Plan:
- Reset: drive rst_n=0 for 2 edges with we_onehot=8'h08, wdata=16'hFFFF -> all reads return 16'h0000 and wsel_err=0; the write is ignored.
- Write/read all registers: write reg i = 16'h1110+i for i=1..7 (we_onehot=1<<i), then read each on both ports -> value appears 1 cycle after enable. Read of reg 0 after we_onehot=8'h01, wdata=16'hBEEF -> 16'h0000, wsel_err=0.
- Multi-hot: we_onehot=8'h0C, wdata=16'hDEAD with reg2=16'h1112, reg3=16'h1113 -> both unchanged and wsel_err=1. wsel_err stays 1 for 5 idle cycles, clears on clr_err, and stays 1 if clr_err coincides with we_onehot=8'h81.
- Collision: write reg5 from 16'h1115 to 16'hA5A5 while ra_en=1, ra_addr=5 on the same edge -> ra_data=16'h1115 without the macro, 16'hA5A5 with REGFILE_BYPASS_EN. Next read returns 16'hA5A5 in both builds.
- Hold: set ra_addr=3, ra_en=1 (ra_data=16'h1113), then ra_en=0, ra_addr=6 and write reg3=16'h0000 -> ra_data stays 16'h1113.
- Reset mid-operation: rst_n=0 on the same edge as we_onehot=8'h40, wdata=16'h7777 and rb_en=1 -> reg6, rb_data and wsel_err all read 0 after reset.
